// File: rtl/dense_dot_acc.sv
// dense_dot_acc: pipelined signed fixed-point dot product with multi-beat accumulation.
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   in_valid/ready  input beat handshake; in_ready = ~(q_valid & ~q_ready)
//   in_first/last   vector framing; in_last emits one result
//   d1, d2          N_LANE signed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   q_valid/ready   result handshake
//   q, q_ovf        scaled result (clamped or wrapped) and range-overflow flag

`ifndef N_LEN
`define N_LEN 16
`endif
`ifndef F_LEN
`define F_LEN 8
`endif

module dense_dot_acc #(
  parameter int DATA_WIDTH = `N_LEN,
  parameter int FRAC_WIDTH = `F_LEN,
  parameter int N_LANE     = 8,
  parameter bit SATURATE   = 1'b1,
  parameter int ACC_GUARD  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [N_LANE*DATA_WIDTH-1:0] d1,
  input  logic [N_LANE*DATA_WIDTH-1:0] d2,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic [DATA_WIDTH-1:0]        q,
  output logic                         q_ovf
);

  localparam int LOG2_N = $clog2(N_LANE);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int TW     = PW + LOG2_N;
  localparam int ACC_W  = TW + ACC_GUARD;
  localparam int NODES  = 2 * N_LANE - 1;
  localparam int TOP_W  = ACC_W - DATA_WIDTH + 1;

  logic en;

  assign en       = ~(q_valid & ~q_ready);
  assign in_ready = en;

  function automatic logic signed [PW-1:0] sext(
    input logic [DATA_WIDTH-1:0] x
  );
    return {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
  endfunction

  logic signed [PW-1:0] prod [N_LANE];

  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      prod[i] = sext(d1[i*DATA_WIDTH +: DATA_WIDTH])
              * sext(d2[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Framing bits ride alongside the data: bit 0 is stage M,
  // bit k is tree level k, bit LOG2_N feeds the accumulator.
  logic [LOG2_N:0] sv;
  logic [LOG2_N:0] sf;
  logic [LOG2_N:0] sl;

  always_ff @(posedge clk) begin
    if (rst) begin
      sv <= '0;
      sf <= '0;
      sl <= '0;
    end else if (en) begin
      sv <= {sv[LOG2_N-1:0], in_valid};
      sf <= {sf[LOG2_N-1:0], in_first};
      sl <= {sl[LOG2_N-1:0], in_last};
    end
  end

  // Flattened adder tree: level k occupies nodes starting at
  // 2*N_LANE - (2*N_LANE >> k); the root is the last node.
  logic signed [TW-1:0] node [NODES];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < N_LANE; i++) begin
        node[i] <= {{LOG2_N{prod[i][PW-1]}}, prod[i]};
      end
      for (int k = 1; k <= LOG2_N; k++) begin
        for (int i = 0; i < (N_LANE >> k); i++) begin
          node[NODES + 1 - ((2 * N_LANE) >> k) + i] <=
            node[NODES + 1 - ((2 * N_LANE) >> (k - 1)) + 2 * i]
          + node[NODES + 1 - ((2 * N_LANE) >> (k - 1)) + 2 * i + 1];
        end
      end
    end
  end

  logic signed [TW-1:0]    sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] r;
  logic [TOP_W-1:0]        top;
  logic                    ovf;
  logic                    neg;
  logic [DATA_WIDTH-1:0]   q_next;
  logic                    t_valid;
  logic                    t_first;
  logic                    t_last;

  assign sum     = node[NODES-1];
  assign t_valid = sv[LOG2_N];
  assign t_first = sf[LOG2_N];
  assign t_last  = sl[LOG2_N];

  always_comb begin
    acc_sum = (t_first ? '0 : acc)
            + {{ACC_GUARD{sum[TW-1]}}, sum};
    r       = acc_sum >>> FRAC_WIDTH;
    // In range only if every bit from DATA_WIDTH-1 up is a sign copy.
    top     = r[ACC_W-1:DATA_WIDTH-1];
    ovf     = (|top) & ~(&top);
    neg     = r[ACC_W-1];
  end

  always_comb begin
    q_next = r[DATA_WIDTH-1:0];
    unique case (1'b1)
      (ovf & SATURATE & ~neg):
        q_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      (ovf & SATURATE & neg):
        q_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      default: ;
    endcase
  end

  // With en high either q_valid is low or it is being taken,
  // so q_valid simply follows whether a result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q_valid <= 1'b0;
      q       <= '0;
      q_ovf   <= 1'b0;
    end else if (en) begin
      if (t_valid) begin
        acc <= t_last ? '0 : acc_sum;
      end
      q_valid <= t_valid & t_last;
      if (t_valid & t_last) begin
        q     <= q_next;
        q_ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_dense_dot_acc.sv
// tb_dense_dot_acc: directed bench for dense_dot_acc, DW=16 FW=8 N_LANE=8.
// Two instances share stimulus: SATURATE=1 (dut) and SATURATE=0 (dut_w).
module tb_dense_dot_acc;

  localparam int DW = 16;
  localparam int NL = 8;
  localparam int W  = DW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_first;
  logic          in_last;
  logic [W-1:0]  d1;
  logic [W-1:0]  d2;
  logic          q_ready;
  logic          in_ready;
  logic          q_valid;
  logic [DW-1:0] q;
  logic          q_ovf;
  logic          in_ready_w;
  logic          q_valid_w;
  logic [DW-1:0] q_w;
  logic          q_ovf_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] got_w[$];

  always #5 clk = ~clk;

  dense_dot_acc #(
    .DATA_WIDTH(16), .FRAC_WIDTH(8), .N_LANE(8),
    .SATURATE(1'b1), .ACC_GUARD(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .d1(d1), .d2(d2),
    .q_valid(q_valid), .q_ready(q_ready),
    .q(q), .q_ovf(q_ovf)
  );

  dense_dot_acc #(
    .DATA_WIDTH(16), .FRAC_WIDTH(8), .N_LANE(8),
    .SATURATE(1'b0), .ACC_GUARD(8)
  ) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_first(in_first), .in_last(in_last),
    .d1(d1), .d2(d2),
    .q_valid(q_valid_w), .q_ready(q_ready),
    .q(q_w), .q_ovf(q_ovf_w)
  );

  function automatic logic [W-1:0] bcast(input logic [DW-1:0] x);
    return {NL{x}};
  endfunction

  function automatic logic [W-1:0] lane0(input logic [DW-1:0] x);
    return {{(W-DW){1'b0}}, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Present one beat and return after the edge that accepts it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic f, input logic l, output logic ok);
    logic rdy;
    in_valid = 1'b1;
    d1 = a;
    d2 = b;
    in_first = f;
    in_last = l;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      rdy = in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
  endtask

  task automatic collect(input int n);
    got_q.delete();
    got_w.delete();
    for (int i = 0; i < n; i++) begin
      if (q_valid && q_ready) got_q.push_back(q);
      if (q_valid_w && q_ready) got_w.push_back(q_w);
      tick();
    end
  endtask

  // Single-beat vector; lat counts edges from driving the beat.
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [DW-1:0] rq, output logic ro,
                            output logic [DW-1:0] rw, output logic rwo,
                            output int lat, output logic got);
    logic ok;
    send(a, b, 1'b1, 1'b1, ok);
    drop();
    lat = 1;
    got = 1'b0;
    while (ok && !got && lat < 12) begin
      if (q_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    rq = q;
    ro = q_ovf;
    rw = q_w;
    rwo = q_ovf_w;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (q_valid !== 1'b0 || q !== 16'h0000 || q_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q_valid=%b q=%h q_ovf=%b want 0 0000 0",
               q_valid, q, q_ovf);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] rq, rw;
    logic ro, rwo, got;
    int lat;
    run_single(bcast(16'h0100), bcast(16'h0200), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (got !== 1'b1 || lat != 5) begin
      n_fail++;
      $display("FAIL single_latency: got=%b lat=%0d want 1 5", got, lat);
    end
    n_checks++;
    if (rq !== 16'h1000 || ro !== 1'b0) begin
      n_fail++;
      $display("FAIL single_q: q=%h ovf=%b want 1000 0", rq, ro);
    end
  endtask

  task automatic test_multi_beat();
    logic ok;
    send(bcast(16'h0100), bcast(16'h0080), 1'b1, 1'b0, ok);
    send(bcast(16'h0100), bcast(16'h0080), 1'b0, 1'b0, ok);
    send(bcast(16'h0100), bcast(16'h0080), 1'b0, 1'b1, ok);
    drop();
    collect(15);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h0C00) begin
      n_fail++;
      $display("FAIL multi_beat: count=%0d q=%h want 1 0c00",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
    // No first flag and a bubble mid-vector: acc was cleared by the
    // previous last, and the bubble must not touch it.
    send(bcast(16'h0100), bcast(16'h0080), 1'b0, 1'b0, ok);
    drop();
    tick();
    tick();
    send(bcast(16'h0100), bcast(16'h0080), 1'b0, 1'b0, ok);
    send(bcast(16'h0100), bcast(16'h0080), 1'b0, 1'b1, ok);
    drop();
    collect(15);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h0C00) begin
      n_fail++;
      $display("FAIL multi_bubble: count=%0d q=%h want 1 0c00",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_floor();
    logic [DW-1:0] rq, rw;
    logic ro, rwo, got;
    int lat;
    run_single(lane0(16'hFFFF), lane0(16'h0001), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'hFFFF || ro !== 1'b0) begin
      n_fail++;
      $display("FAIL floor_neg: q=%h ovf=%b want ffff 0", rq, ro);
    end
    run_single(lane0(16'h0001), lane0(16'h0001), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h0000 || ro !== 1'b0) begin
      n_fail++;
      $display("FAIL floor_pos: q=%h ovf=%b want 0000 0", rq, ro);
    end
  endtask

  task automatic test_lanes();
    logic [DW-1:0] rq, rw;
    logic ro, rwo, got;
    logic [W-1:0] ramp;
    int lat;
    for (int i = 0; i < NL; i++) ramp[i*DW +: DW] = 16'((i + 1) * 256);
    // 1+2+...+8 = 36.0
    run_single(ramp, bcast(16'h0100), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h2400 || rw !== 16'h2400) begin
      n_fail++;
      $display("FAIL lanes_ramp: q=%h qw=%h want 2400 2400", rq, rw);
    end
    // 8 * (-1.0 * 3.0) = -24.0
    run_single(bcast(16'hFF00), bcast(16'h0300), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'hE800 || ro !== 1'b0 || rw !== 16'hE800) begin
      n_fail++;
      $display("FAIL lanes_neg: q=%h ovf=%b qw=%h want e800 0 e800",
               rq, ro, rw);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] rq, rw;
    logic ro, rwo, got;
    int lat;
    run_single(bcast(16'h7FFF), bcast(16'h7FFF), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h7FFF || ro !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos_sat: q=%h ovf=%b want 7fff 1", rq, ro);
    end
    n_checks++;
    if (!got || rw !== 16'hF800 || rwo !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos_wrap: q=%h ovf=%b want f800 1", rw, rwo);
    end
    run_single(bcast(16'h8000), bcast(16'h7FFF), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h8000 || ro !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg_sat: q=%h ovf=%b want 8000 1", rq, ro);
    end
    n_checks++;
    if (!got || rw !== 16'h0400 || rwo !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg_wrap: q=%h ovf=%b want 0400 1", rw, rwo);
    end
    run_single(lane0(16'h7FFF), lane0(16'h0100), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h7FFF || ro !== 1'b0 || rwo !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_max: q=%h ovf=%b ovfw=%b want 7fff 0 0",
               rq, ro, rwo);
    end
    run_single(lane0(16'h8000), lane0(16'h0100), rq, ro, rw, rwo, lat, got);
    n_checks++;
    if (!got || rq !== 16'h8000 || ro !== 1'b0 || rw !== 16'h8000) begin
      n_fail++;
      $display("FAIL edge_min: q=%h ovf=%b qw=%h want 8000 0 8000",
               rq, ro, rw);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [DW-1:0] exp_q [4];
    int waited;
    q_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(bcast(16'(k * 256)), bcast(16'h0100), 1'b1, 1'b1, ok);
      exp_q[k-1] = 16'(k * 2048);
    end
    drop();
    waited = 0;
    while (!q_valid && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: q_valid=%b want 1 within 20 cycles", q_valid);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (q_valid !== 1'b1 || in_ready !== 1'b0 || q !== 16'h0800) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: q_valid=%b in_ready=%b q=%h want 1 0 0800",
                 c, q_valid, in_ready, q);
      end
      tick();
    end
    q_ready = 1'b1;
    collect(20);
    n_checks++;
    if (got_q.size() != 4 || got_w.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d/%0d results want 4/4",
               got_q.size(), got_w.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: q=%h want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    send(bcast(16'h0100), bcast(16'h0200), 1'b1, 1'b0, ok);
    send(bcast(16'h0100), bcast(16'h0200), 1'b0, 1'b0, ok);
    drop();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: in_ready=%b q_valid=%b want 1 0",
               in_ready, q_valid);
    end
    send(bcast(16'h0100), bcast(16'h0200), 1'b1, 1'b1, ok);
    drop();
    collect(15);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h1000) begin
      n_fail++;
      $display("FAIL rst_mid_result: count=%0d q=%h want 1 1000",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
    // Partial sum parked in acc, then reset; a last without first
    // must then see a clean accumulator.
    send(bcast(16'h0100), bcast(16'h0200), 1'b1, 1'b0, ok);
    drop();
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(bcast(16'h0100), bcast(16'h0200), 1'b0, 1'b1, ok);
    drop();
    collect(15);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h1000) begin
      n_fail++;
      $display("FAIL rst_acc_clear: count=%0d q=%h want 1 1000",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    d1 = '0;
    d2 = '0;
    q_ready = 1'b1;
    test_reset();
    test_single();
    test_multi_beat();
    test_floor();
    test_lanes();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
